// File: rtl/sonido_pkg.sv
// sonido_pkg
// Shared constants for the sonido I2S-style audio transmitter.
//   DATA_W, SLOT_BITS, CLK_PER_BIT : default sample width / slots per channel /
//                                    clk cycles per serial bit slot
//   FRAME_CLKS, CNT_W              : derived frame length and counter width
//   MSB_SLOT, LAST_DATA_SLOT       : first and last bit slot carrying sample data
//                                    (slot 0 is the I2S one-bit delay)
package sonido_pkg;

    localparam int DATA_W      = 24;
    localparam int SLOT_BITS   = 32;
    localparam int CLK_PER_BIT = 8;

    localparam int FRAME_CLKS  = 2 * SLOT_BITS * CLK_PER_BIT;
    localparam int CNT_W       = $clog2(FRAME_CLKS);

    localparam int MSB_SLOT       = 1;
    localparam int LAST_DATA_SLOT = MSB_SLOT + DATA_W - 1;

    function automatic int frame_clks(input int slot_bits, input int clk_per_bit);
        return 2 * slot_bits * clk_per_bit;
    endfunction

endpackage

// File: rtl/sonido_clkgen.sv
// sonido_clkgen
// Free-running frame counter and the DAC clock outputs.
// All clock outputs are registered from the next counter value, so in the
// cycle where cnt = n every output already reflects position n.
// Ports:
//   clk, reset    : system clock, asynchronous active-low reset
//   cnt           : current frame position, 0..FRAME-1
//   slot_next     : bit slot (0..SLOT_BITS-1) of the next frame position,
//                   used by the top to register SDIN in step with the clocks
//   frame_start   : high in the last cycle of a frame; the following edge
//                   wraps cnt to 0 and starts a new frame
//   mclk          : clk/2 master clock (0 on even positions)
//   lrclk         : word select, 0 = left half, 1 = right half
//   sclk          : serial bit clock, only with SONIDO_SCLK_EN defined
// Macro: SONIDO_SCLK_EN adds the sclk output.
module sonido_clkgen
    import sonido_pkg::*;
#(
    parameter int SLOT_BITS   = sonido_pkg::SLOT_BITS,
    parameter int CLK_PER_BIT = sonido_pkg::CLK_PER_BIT,
    localparam int FRAME      = frame_clks(SLOT_BITS, CLK_PER_BIT),
    localparam int CW         = $clog2(FRAME),
    localparam int SW         = $clog2(SLOT_BITS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] cnt,
    output logic [SW-1:0] slot_next,
    output logic          frame_start,
    output logic          mclk,
`ifdef SONIDO_SCLK_EN
    output logic          sclk,
`endif
    output logic          lrclk
);

    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] HALF = CW'(FRAME / 2);
    localparam logic [CW-1:0] CPB  = CW'(CLK_PER_BIT);

    logic [CW-1:0] cnt_next;
    logic [CW-1:0] pos_next;
    logic          lrclk_next;

    // Explicit wrap keeps the frame correct for non-power-of-two CLK_PER_BIT.
    always_comb begin
        cnt_next   = (cnt == LAST) ? '0 : cnt + 1'b1;
        lrclk_next = (cnt_next >= HALF);
        pos_next   = lrclk_next ? (cnt_next - HALF) : cnt_next;
    end

    assign slot_next   = SW'(pos_next / CPB);
    assign frame_start = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            mclk  <= 1'b0;
            lrclk <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            mclk  <= cnt_next[0];
            lrclk <= lrclk_next;
        end
    end

`ifdef SONIDO_SCLK_EN
    localparam logic [CW-1:0] CPB_HALF = CW'(CLK_PER_BIT / 2);

    logic [CW-1:0] phase_next;

    assign phase_next = pos_next % CPB;

    // Low for the first half of each slot: SDIN changes at the slot start,
    // so it has been stable for half a slot when sclk rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk <= 1'b0;
        end else begin
            sclk <= (phase_next >= CPB_HALF);
        end
    end
`endif

endmodule

// File: rtl/sonido.sv
// sonido
// Serial audio transmitter for a 24-bit I2S-style stereo DAC Pmod.
// One sample is latched per frame and sent MSB-first, one slot after the
// word-select change, identically on the left and right channels.
// Ports:
//   clk            : 50 MHz system clock
//   reset          : asynchronous active-low reset
//   transmisionIn  : two's-complement sample, captured at the frame wrap
//   MCLK           : DAC master clock, clk/2
//   LRCLK          : word select, 0 = left, 1 = right
//   SDIN           : serial data
//   SCLK           : serial bit clock (only with SONIDO_SCLK_EN)
//   gnd, vcc       : Pmod supply pins, constant 0 / 1
// Macro: SONIDO_SCLK_EN adds the SCLK output port.
module sonido
    import sonido_pkg::*;
#(
    parameter int DATA_W      = sonido_pkg::DATA_W,
    parameter int SLOT_BITS   = sonido_pkg::SLOT_BITS,
    parameter int CLK_PER_BIT = sonido_pkg::CLK_PER_BIT,
    localparam int FRAME      = frame_clks(SLOT_BITS, CLK_PER_BIT),
    localparam int CW         = $clog2(FRAME),
    localparam int SW         = $clog2(SLOT_BITS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] transmisionIn,
    output logic              MCLK,
    output logic              LRCLK,
    output logic              SDIN,
`ifdef SONIDO_SCLK_EN
    output logic              SCLK,
`endif
    output logic              gnd,
    output logic              vcc
);

    logic [CW-1:0]     cnt_unused;   // frame position, kept visible for debug
    logic [SW-1:0]     slot_next;
    logic              frame_start;
    logic [DATA_W-1:0] hold;
    logic              sdin_d;

    sonido_clkgen #(
        .SLOT_BITS   (SLOT_BITS),
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_clkgen (
        .clk         (clk),
        .reset       (reset),
        .cnt         (cnt_unused),
        .slot_next   (slot_next),
        .frame_start (frame_start),
        .mclk        (MCLK),
`ifdef SONIDO_SCLK_EN
        .sclk        (SCLK),
`endif
        .lrclk       (LRCLK)
    );

    assign gnd = 1'b0;
    assign vcc = 1'b1;

    // Sample is frozen for the whole frame, so mid-frame input changes only
    // show up in the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold <= '0;
        end else if (frame_start) begin
            hold <= transmisionIn;
        end
    end

    // Slot MSB_SLOT carries hold[DATA_W-1], the following slots walk down to
    // bit 0; slot 0 and the slots after the data are zero. slot_next only
    // changes on slot boundaries, and hold only changes while slot_next = 0,
    // so SDIN moves only at the start of a slot.
    always_comb begin
        sdin_d = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(slot_next) == MSB_SLOT + DATA_W - 1 - i) begin
                sdin_d = hold[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            SDIN <= 1'b0;
        end else begin
            SDIN <= sdin_d;
        end
    end

endmodule

// File: tb/tb_sonido.sv
// tb_sonido
// Directed bench for sonido: reset state, frame timing, sample serialisation,
// mid-frame input change and mid-frame asynchronous reset.
module tb_sonido;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] transmisionIn;
    logic        MCLK, LRCLK, SDIN, gnd, vcc;
`ifdef SONIDO_SCLK_EN
    logic        SCLK;
`endif

    int checks   = 0;
    int failures = 0;
    int tpos     = 0;       // expected frame position of the DUT

    always #5 clk = ~clk;

    sonido dut (
        .clk           (clk),
        .reset         (reset),
        .transmisionIn (transmisionIn),
        .MCLK          (MCLK),
        .LRCLK         (LRCLK),
        .SDIN          (SDIN),
`ifdef SONIDO_SCLK_EN
        .SCLK          (SCLK),
`endif
        .gnd           (gnd),
        .vcc           (vcc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h pos=%0d", tag, obs, exp, tpos);
        end
    endtask

    function automatic logic exp_sdin(input int pos, input logic [23:0] s);
        int b;
        b = (pos % 256) / 8;
        if (b >= 1 && b <= 24) return s[24 - b];
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        tpos = (tpos + 1) % 512;
        @(negedge clk);
    endtask

    task automatic check_cycle(input logic [23:0] s);
        chk("mclk",  MCLK,  32'(tpos % 2));
        chk("lrclk", LRCLK, 32'(tpos >= 256));
        chk("sdin",  SDIN,  32'(exp_sdin(tpos, s)));
`ifdef SONIDO_SCLK_EN
        chk("sclk",  SCLK,  32'((tpos % 8) >= 4));
`endif
    endtask

    // Runs one frame from position 0 to the next wrap, checking every cycle.
    // exp_hi is the hand-counted number of SDIN-high cycles per channel.
    task automatic run_frame(input logic [23:0] s, input int chg_pos,
                             input logic [23:0] chg_val, input int exp_hi,
                             output logic [23:0] next_s);
        int hi_l, hi_r;
`ifdef SONIDO_SCLK_EN
        int  rises;
        logic prev;
        rises = 0;
        prev  = SCLK;
`endif
        hi_l = 0;
        hi_r = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            check_cycle(s);
            if (SDIN === 1'b1) begin
                if (tpos < 256) hi_l++;
                else            hi_r++;
            end
`ifdef SONIDO_SCLK_EN
            if (prev === 1'b0 && SCLK === 1'b1) rises++;
            prev = SCLK;
`endif
            if (tpos == chg_pos) transmisionIn = chg_val;
        end
        chk("hi_cycles_left",  32'(hi_l), 32'(exp_hi));
        chk("hi_cycles_right", 32'(hi_r), 32'(exp_hi));
`ifdef SONIDO_SCLK_EN
        chk("sclk_rises", 32'(rises), 32'd64);
`endif
        // The DUT captured whatever the bench was driving at the wrap edge.
        next_s = transmisionIn;
    endtask

    initial begin
        logic [23:0] cur, nxt;

        reset         = 1'b0;
        transmisionIn = 24'h000000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mclk",  MCLK,  32'd0);
        chk("rst_lrclk", LRCLK, 32'd0);
        chk("rst_sdin",  SDIN,  32'd0);
        chk("rst_gnd",   gnd,   32'd0);
        chk("rst_vcc",   vcc,   32'd1);
`ifdef SONIDO_SCLK_EN
        chk("rst_sclk",  SCLK,  32'd0);
`endif

        // Release; first frame sends zero while 0x000065 waits at the input.
        reset         = 1'b1;
        tpos          = 0;
        transmisionIn = 24'h000065;
        run_frame(24'h000000, -1, 24'h0, 0, nxt);

        // 0x000065 has 4 ones -> 32 high cycles per channel. Input changes to
        // 0x800000 mid-frame without affecting this frame.
        run_frame(24'h000065, 50, 24'h800000, 32, nxt);

        // 0x800000: only slot 1 high, 8 clk per channel. 0x00012D arrives at
        // position 100 and must wait for the next frame.
        run_frame(24'h800000, 100, 24'h00012D, 8, nxt);

        // 0x00012D has 5 ones -> 40 high cycles per channel.
        run_frame(24'h00012D, -1, 24'h0, 40, nxt);

        // Mid-frame reset at position 300.
        cur = 24'h00012D;
        for (int i = 0; i < 512 && tpos != 300; i++) begin
            step();
            check_cycle(cur);
        end
        chk("pre_abort_pos", 32'(tpos), 32'd300);
        chk("pre_abort_lrclk", LRCLK, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_mclk",  MCLK,  32'd0);
        chk("abort_lrclk", LRCLK, 32'd0);
        chk("abort_sdin",  SDIN,  32'd0);
`ifdef SONIDO_SCLK_EN
        chk("abort_sclk",  SCLK,  32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("held_lrclk", LRCLK, 32'd0);
        chk("held_mclk",  MCLK,  32'd0);
        reset = 1'b1;
        tpos  = 0;

        // Hold was cleared by reset: the first frame after release sends 0.
        run_frame(24'h000000, -1, 24'h0, 0, nxt);
        run_frame(24'h00012D, -1, 24'h0, 40, nxt);

        chk("end_gnd", gnd, 32'd0);
        chk("end_vcc", vcc, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
